// File: rtl/vmemarb.sv
// vmemarb: video-memory arbiter for the PPU bus.
//
// Three requesters share one bus: background fetch (port 0), sprite fetch
// (port 1) and CPU $2007 access (port 2), with fixed priority 0 > 1 > 2.
// Each granted address is routed to one of two targets:
//   - below $2000: the cartridge CHR bus (req/ack handshake, with timeout)
//   - $2000-$3FFF: the internal 2 KB CIRAM, banked by the cartridge mirroring
// The winner gets a one-cycle ack pulse. For reads, rdata is valid with that
// pulse and held until the next completion.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req[2:0]            per-port request level, held until that port's ack
//   addr0..2, wr[2:0],  per-port address, write flag and write data
//   wdata0..2
//   ack[2:0], rdata     one-hot completion pulse and read data
//   chraddr, chrwdata,  CHR bus request side; chrwr is qualified by chrreq
//   chrwr, chrreq
//   chrack, chrrdata    CHR bus completion pulse and read data
//   ciramaddr,          CIRAM access; ciramen is a one-cycle strobe and
//   ciramwdata,         ciramrdata is valid the cycle after it
//   ciramen, ciramwr,
//   ciramrdata
//   mirror              0=horizontal 1=vertical 2=single A 3=single B
//   busy                high whenever the arbiter is not idle
//   err, errclr         sticky CHR timeout flag and its clear
module vmemarb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [13:0] addr0,
  input  logic [13:0] addr1,
  input  logic [13:0] addr2,
  input  logic [2:0]  wr,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  input  logic [7:0]  wdata2,
  output logic [2:0]  ack,
  output logic [7:0]  rdata,
  output logic [13:0] chraddr,
  output logic [7:0]  chrwdata,
  output logic        chrwr,
  output logic        chrreq,
  input  logic        chrack,
  input  logic [7:0]  chrrdata,
  output logic [10:0] ciramaddr,
  output logic [7:0]  ciramwdata,
  output logic        ciramen,
  output logic        ciramwr,
  input  logic [7:0]  ciramrdata,
  input  logic [1:0]  mirror,
  output logic        busy,
  output logic        err,
  input  logic        errclr
);

  typedef enum logic [2:0] {IDLE, NTRD, NTDAT, CHRWAIT, RESP} state_t;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  port_q, port_d;
  logic        wr_q, wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [13:0] chraddr_q, chraddr_d;
  logic [7:0]  chrwdata_q, chrwdata_d;
  logic        chrwr_q, chrwr_d;
  logic        chrreq_q, chrreq_d;
  logic [10:0] ciramaddr_q, ciramaddr_d;
  logic [7:0]  ciramwdata_q, ciramwdata_d;
  logic        ciramen_q, ciramen_d;
  logic        ciramwr_q, ciramwr_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [1:0]  winPort;
  logic [13:0] selAddr;
  logic        selWr;
  logic [7:0]  selWdata;
  logic        ntBank;
  logic        timeoutHit;

  // Fixed-priority pick of the request to serve next.
  always_comb begin
    winPort  = 2'd0;
    selAddr  = addr0;
    selWr    = wr[0];
    selWdata = wdata0;
    if (!req[0] && req[1]) begin
      winPort  = 2'd1;
      selAddr  = addr1;
      selWr    = wr[1];
      selWdata = wdata1;
    end else if (!req[0] && !req[1] && req[2]) begin
      winPort  = 2'd2;
      selAddr  = addr2;
      selWr    = wr[2];
      selWdata = wdata2;
    end
  end

  // Physical CIRAM bank for the four logical nametables. addr[12] is ignored,
  // which folds $3000-$3FFF onto $2000-$2FFF.
  always_comb begin
    case (mirror)
      2'd0:    ntBank = selAddr[11];
      2'd1:    ntBank = selAddr[10];
      2'd2:    ntBank = 1'b0;
      default: ntBank = 1'b1;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    ack_d        = 3'b000;
    rdata_d      = rdata_q;
    chraddr_d    = chraddr_q;
    chrwdata_d   = chrwdata_q;
    chrwr_d      = chrwr_q;
    chrreq_d     = chrreq_q;
    ciramaddr_d  = ciramaddr_q;
    ciramwdata_d = ciramwdata_q;
    ciramen_d    = 1'b0;
    ciramwr_d    = 1'b0;
    timeoutHit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          port_d = winPort;
          wr_d   = selWr;
          if (selAddr[13]) begin
            state_d      = NTRD;
            ciramen_d    = 1'b1;
            ciramwr_d    = selWr;
            ciramaddr_d  = {ntBank, selAddr[9:0]};
            ciramwdata_d = selWdata;
          end else begin
            state_d    = CHRWAIT;
            chrreq_d   = 1'b1;
            chraddr_d  = selAddr;
            chrwr_d    = selWr;
            chrwdata_d = selWdata;
            cnt_d      = 8'd0;
          end
        end
      end
      NTRD: begin
        state_d = NTDAT;
      end
      NTDAT: begin
        if (!wr_q) rdata_d = ciramrdata;
        ack_d   = 3'b001 << port_q;
        state_d = RESP;
      end
      CHRWAIT: begin
        // A completion arriving on the same edge the count expires still wins.
        if (chrack) begin
          chrreq_d = 1'b0;
          if (!wr_q) rdata_d = chrrdata;
          ack_d    = 3'b001 << port_q;
          state_d  = RESP;
        end else if ((cnt_q + 8'd1) == TimeoutCnt) begin
          chrreq_d   = 1'b0;
          if (!wr_q) rdata_d = 8'hFF;
          timeoutHit = 1'b1;
          ack_d      = 3'b001 << port_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A timeout on the same edge as errclr leaves the flag set.
    err_d  = timeoutHit ? 1'b1 : (errclr ? 1'b0 : err_q);
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      port_q       <= 2'd0;
      wr_q         <= 1'b0;
      cnt_q        <= 8'd0;
      ack_q        <= 3'b000;
      rdata_q      <= 8'd0;
      chraddr_q    <= 14'd0;
      chrwdata_q   <= 8'd0;
      chrwr_q      <= 1'b0;
      chrreq_q     <= 1'b0;
      ciramaddr_q  <= 11'd0;
      ciramwdata_q <= 8'd0;
      ciramen_q    <= 1'b0;
      ciramwr_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      chraddr_q    <= chraddr_d;
      chrwdata_q   <= chrwdata_d;
      chrwr_q      <= chrwr_d;
      chrreq_q     <= chrreq_d;
      ciramaddr_q  <= ciramaddr_d;
      ciramwdata_q <= ciramwdata_d;
      ciramen_q    <= ciramen_d;
      ciramwr_q    <= ciramwr_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign chraddr    = chraddr_q;
  assign chrwdata   = chrwdata_q;
  assign chrwr      = chrwr_q;
  assign chrreq     = chrreq_q;
  assign ciramaddr  = ciramaddr_q;
  assign ciramwdata = ciramwdata_q;
  assign ciramen    = ciramen_q;
  assign ciramwr    = ciramwr_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vmemarb.sv
// tb_vmemarb: self-checking bench for vmemarb.
//
// Each batch raises a set of requests in one cycle. A reference schedule is
// then built from the arbiter's external timing rules: priority order,
// 3 cycles to ack for CIRAM, chrack latency + 1 (capped at TIMEOUT + 1) for
// CHR, and one idle cycle between completions. Every cycle, ack, busy,
// ciramen, chrreq, rdata and err are compared with that schedule. The bench
// also models the CIRAM and CHR devices attached to the arbiter.
module tb_vmemarb;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [13:0] addr0, addr1, addr2;
  logic [2:0]  wr;
  logic [7:0]  wdata0, wdata1, wdata2;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic [13:0] chraddr;
  logic [7:0]  chrwdata;
  logic        chrwr, chrreq, chrack;
  logic [7:0]  chrrdata;
  logic [10:0] ciramaddr;
  logic [7:0]  ciramwdata;
  logic        ciramen, ciramwr;
  logic [7:0]  ciramrdata;
  logic [1:0]  mirror;
  logic        busy, err, errclr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  envMem [2048];
  logic [7:0]  refMem [2048];
  logic [13:0] bAddr [3];
  logic        bWr [3];
  logic [7:0]  bWdata [3];
  int          bLat [3];
  logic [7:0]  bChr [3];

  logic [7:0]  lastRdata = 8'd0;
  logic        expErr = 1'b0;
  int          curLat = 0;
  logic [7:0]  curChr = 8'd0;
  bit          strayEn = 1'b0;
  bit          errclrEn = 1'b0;
  logic        pendEn = 1'b0, pendWr = 1'b0;
  logic [10:0] pendAddr = 11'd0;
  logic [7:0]  pendWdata = 8'd0;
  int          chrCnt = 0;

  vmemarb #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wr(wr), .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .ack(ack), .rdata(rdata),
    .chraddr(chraddr), .chrwdata(chrwdata), .chrwr(chrwr), .chrreq(chrreq),
    .chrack(chrack), .chrrdata(chrrdata),
    .ciramaddr(ciramaddr), .ciramwdata(ciramwdata), .ciramen(ciramen),
    .ciramwr(ciramwr), .ciramrdata(ciramrdata),
    .mirror(mirror), .busy(busy), .err(err), .errclr(errclr)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch as a failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Physical CIRAM address: logical table 0..3 is picked by addr[11:10] and
  // mapped onto one of the two 1 KB physical banks.
  function automatic logic [10:0] mirAddr(input logic [13:0] a, input logic [1:0] m);
    int tbl;
    int phys;
    tbl = int'(a[11:10]);
    case (m)
      2'd0:    phys = tbl / 2;
      2'd1:    phys = tbl % 2;
      2'd2:    phys = 0;
      default: phys = 1;
    endcase
    return 11'(phys * 1024 + int'(a[9:0]));
  endfunction

  // Advance one cycle and sample 1 time unit after the edge. Afterwards,
  // drive the device models. CIRAM returns data the cycle after its strobe.
  // CHR acks when the current access has held chrreq for curLat cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pendEn) begin
      if (pendWr) begin
        envMem[pendAddr] = pendWdata;
        ciramrdata = 8'($urandom);
      end else begin
        ciramrdata = envMem[pendAddr];
      end
    end else begin
      ciramrdata = 8'($urandom);
    end
    pendEn    = ciramen;
    pendWr    = ciramwr;
    pendAddr  = ciramaddr;
    pendWdata = ciramwdata;
    chrack   = 1'b0;
    chrrdata = 8'($urandom);
    if (chrreq === 1'b1) begin
      chrCnt++;
      if (chrCnt == curLat) begin
        chrack   = 1'b1;
        chrrdata = curChr;
      end
    end else begin
      chrCnt = 0;
      if (strayEn && $urandom_range(0, 7) == 0) chrack = 1'b1;
    end
  endtask

  // Run one batch of requests raised together and check it cycle by cycle.
  task automatic applyStimulus(input logic [2:0] mask, input logic [1:0] mir, input int gap);
    int ackS [3];
    int fromS [3];
    int chrN [3];
    logic [10:0] ma [3];
    int d, prev, r;
    logic [2:0] expAck;
    logic expBusy, expEn, expChr, toNow, clrPrev;
    r = cyc;
    prev = -1;
    for (int p = 0; p < 3; p++) begin
      ackS[p]  = -100;
      fromS[p] = -100;
      chrN[p]  = 0;
      ma[p]    = mirAddr(bAddr[p], mir);
      if (mask[p]) begin
        if (bAddr[p][13]) d = 3;
        else if (bLat[p] >= 1 && bLat[p] <= TO) d = bLat[p] + 1;
        else d = TO + 1;
        if (!bAddr[p][13]) chrN[p] = d - 1;
        ackS[p]  = (prev < 0) ? r + d : prev + d + 1;
        fromS[p] = ackS[p] - d + 1;
        prev     = ackS[p];
      end
    end
    mirror = mir;
    addr0 = bAddr[0]; addr1 = bAddr[1]; addr2 = bAddr[2];
    wdata0 = bWdata[0]; wdata1 = bWdata[1]; wdata2 = bWdata[2];
    wr  = {bWr[2], bWr[1], bWr[0]};
    req = mask;
    for (int p = 2; p >= 0; p--) if (mask[p]) begin
      curLat = bLat[p];
      curChr = bChr[p];
    end
    while (cyc < prev + gap) begin
      clrPrev = errclr;
      tick();
      expAck = 3'b000; expBusy = 1'b0; expEn = 1'b0; expChr = 1'b0; toNow = 1'b0;
      for (int p = 0; p < 3; p++) if (mask[p]) begin
        if (cyc == ackS[p]) expAck[p] = 1'b1;
        if (cyc >= fromS[p] && cyc <= ackS[p]) expBusy = 1'b1;
        if (bAddr[p][13] && cyc == fromS[p]) begin
          expEn = 1'b1;
          checkOutput("ciramaddr", 32'(ciramaddr), 32'(ma[p]));
          checkOutput("ciramwr", 32'(ciramwr), 32'(bWr[p]));
          if (bWr[p]) checkOutput("ciramwdata", 32'(ciramwdata), 32'(bWdata[p]));
        end
        if (!bAddr[p][13] && cyc >= fromS[p] && cyc < fromS[p] + chrN[p]) begin
          expChr = 1'b1;
          if (cyc == fromS[p]) begin
            checkOutput("chraddr", 32'(chraddr), 32'(bAddr[p]));
            checkOutput("chrwr", 32'(chrwr), 32'(bWr[p]));
            if (bWr[p]) checkOutput("chrwdata", 32'(chrwdata), 32'(bWdata[p]));
          end
        end
      end
      checkOutput("ack", 32'(ack), 32'(expAck));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("ciramen", 32'(ciramen), 32'(expEn));
      checkOutput("chrreq", 32'(chrreq), 32'(expChr));
      for (int p = 0; p < 3; p++) if (expAck[p]) begin
        if (bAddr[p][13]) begin
          if (bWr[p]) refMem[ma[p]] = bWdata[p];
          else lastRdata = refMem[ma[p]];
        end else if (bLat[p] >= 1 && bLat[p] <= TO) begin
          if (!bWr[p]) lastRdata = bChr[p];
        end else begin
          toNow = 1'b1;
          if (!bWr[p]) lastRdata = 8'hFF;
        end
      end
      checkOutput("rdata", 32'(rdata), 32'(lastRdata));
      expErr = toNow ? 1'b1 : (clrPrev ? 1'b0 : expErr);
      checkOutput("err", 32'(err), 32'(expErr));
      req = req & ~ack;
      errclr = errclrEn && ($urandom_range(0, 11) == 0);
      curLat = 0;
      for (int p = 2; p >= 0; p--) if (mask[p] && ackS[p] > cyc) begin
        curLat = bLat[p];
        curChr = bChr[p];
      end
    end
    req = 3'b000;
    errclr = 1'b0;
  endtask

  // Fill in one port's access for the next batch.
  task automatic setPort(input int p, input logic [13:0] a, input logic w,
                         input logic [7:0] wd, input int lat, input logic [7:0] cd);
    bAddr[p] = a; bWr[p] = w; bWdata[p] = wd; bLat[p] = lat; bChr[p] = cd;
  endtask

  // Directed scenarios first, then randomized batches, then the summary.
  initial begin
    logic [7:0] v;
    logic [2:0] m;
    logic [13:0] a;
    reset = 1'b1; req = 3'b000; addr0 = '0; addr1 = '0; addr2 = '0;
    wr = 3'b000; wdata0 = '0; wdata1 = '0; wdata2 = '0;
    chrack = 1'b0; chrrdata = '0; ciramrdata = '0; mirror = 2'd0; errclr = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      v = 8'($urandom);
      envMem[i] = v;
      refMem[i] = v;
    end
    for (int p = 0; p < 3; p++) setPort(p, 14'd0, 1'b0, 8'd0, 1, 8'd0);

    // Reset state.
    tick();
    tick();
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_rdata", 32'(rdata), 32'd0);
    checkOutput("reset_chrreq", 32'(chrreq), 32'd0);
    checkOutput("reset_ciramen", 32'(ciramen), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();

    // Vertical mirroring: read $2400 lands in bank 1.
    envMem[11'h400] = 8'h5A;
    refMem[11'h400] = 8'h5A;
    setPort(0, 14'h2400, 1'b0, 8'h00, 1, 8'h00);
    applyStimulus(3'b001, 2'd1, 2);

    // Horizontal mirroring: CPU write to $2C10.
    setPort(2, 14'h2C10, 1'b1, 8'h33, 1, 8'h00);
    applyStimulus(3'b100, 2'd0, 2);

    // All three ports at once, nametable reads.
    setPort(0, 14'h2000, 1'b0, 8'h00, 1, 8'h00);
    setPort(1, 14'h2801, 1'b0, 8'h00, 1, 8'h00);
    setPort(2, 14'h33C5, 1'b0, 8'h00, 1, 8'h00);
    applyStimulus(3'b111, 2'd1, 2);

    // CHR read completed after 5 cycles.
    setPort(1, 14'h1FF8, 1'b0, 8'h00, 5, 8'hC3);
    applyStimulus(3'b010, 2'd0, 2);

    // CHR read never acknowledged: timeout, then clear the flag.
    setPort(0, 14'h0123, 1'b0, 8'h00, 0, 8'h00);
    applyStimulus(3'b001, 2'd0, 2);
    errclr = 1'b1;
    tick();
    errclr = 1'b0;
    expErr = 1'b0;
    checkOutput("errclr", 32'(err), 32'd0);

    // Reset in the middle of a CHR access.
    setPort(1, 14'h0456, 1'b0, 8'h00, 0, 8'h00);
    curLat = 0;
    addr1 = bAddr[1]; wr = 3'b000; req = 3'b010;
    tick(); tick(); tick();
    checkOutput("pre_reset_chrreq", 32'(chrreq), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_chrreq", 32'(chrreq), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_ack", 32'(ack), 32'd0);
    checkOutput("async_rdata", 32'(rdata), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req = 3'b000;
    chrack = 1'b1;
    lastRdata = 8'd0;
    expErr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("late_chrack_ack", 32'(ack), 32'd0);
      checkOutput("late_chrack_busy", 32'(busy), 32'd0);
    end
    setPort(2, 14'h2A55, 1'b0, 8'h00, 1, 8'h00);
    applyStimulus(3'b100, 2'd2, 2);

    // Randomized batches with stray chrack pulses and random errclr.
    strayEn = 1'b1;
    errclrEn = 1'b1;
    for (int n = 0; n < 150; n++) begin
      m = 3'($urandom_range(1, 7));
      for (int p = 0; p < 3; p++) begin
        a = 14'($urandom);
        if (p == 2 && a >= 14'h3F00) a[8] = 1'b0;
        setPort(p, a, 1'($urandom), 8'($urandom), $urandom_range(1, TO + 2), 8'($urandom));
      end
      applyStimulus(m, 2'($urandom), $urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vmemarb.md
Name: vmemarb

Overview:
- Shares the PPU video-memory bus between three requesters: background fetch (port 0), sprite fetch (port 1) and CPU $2007 data access (port 2).
- Decodes each granted address to one of two targets:
  - CHR space, below $2000: the external cartridge bus, which uses a req/ack handshake.
  - Nametable space, $2000-$3FFF: internal 2 KB CIRAM with cartridge-selected mirroring.
- Returns a one-cycle ack and read data to the winner. Replaces the direct vmemreq/vmemack wiring between the PPU fetchers and memory.

Parameters:
TIMEOUT, 255: cycles to wait for chrack before abandoning a CHR access (1..255).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  3  per-port request level; [0]=bg, [1]=spr, [2]=cpu; held until that port's ack
addr0, addr1, addr2  in  14 each  per-port vmem address
wr  in  3  per-port write flag, valid while req high
wdata0, wdata1, wdata2  in  8 each  per-port write data
ack  out  3  per-port one-cycle completion pulse
rdata  out  8  read data; valid with ack, held until next completion
chraddr  out  14  CHR bus address
chrwdata  out  8  CHR bus write data
chrwr  out  1  CHR bus write strobe, qualified by chrreq
chrreq  out  1  CHR bus request level
chrack  in  1  CHR bus completion, one cycle
chrrdata  in  8  CHR bus read data, valid with chrack
ciramaddr  out  11  CIRAM address
ciramwdata  out  8  CIRAM write data
ciramen  out  1  CIRAM enable, one cycle
ciramwr  out  1  CIRAM write, qualified by ciramen
ciramrdata  in  8  CIRAM read data, valid the cycle after ciramen
mirror  in  2  0=horizontal, 1=vertical, 2=single-screen A, 3=single-screen B
busy  out  1  high in every state except IDLE
err  out  1  sticky CHR-timeout flag
errclr  in  1  clears err

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset asserted mid-access aborts it with no ack. chrreq drops immediately and the outstanding chrack is ignored.
- All outputs are registered.
- States: IDLE, NTRD, NTDAT, CHRWAIT, RESP.
- IDLE:
  - Sample req each edge. Fixed priority: port 0 > port 1 > port 2.
  - Latch the winner's index, addr, wr and wdata. Losers keep req high and are served later.
  - Winner addr[13]=1: go to NTRD. Drive ciramen=1, ciramwr=wr and ciramwdata for exactly one cycle.
  - Winner addr[13]=0: go to CHRWAIT. Set chrreq=1; chraddr=addr, chrwr=wr, chrwdata=wdata.
- Mirroring:
  - ciramaddr[9:0] = addr[9:0].
  - ciramaddr[10] = addr[11] for horizontal; addr[10] for vertical; 0 for single-screen A; 1 for single-screen B.
  - $3000-$3FFF aliases $2000-$2FFF. No palette handling is done here; port 2 must not request palette addresses.
  - mirror is sampled at grant.
- NTRD -> NTDAT -> RESP:
  - At the NTDAT edge, latch rdata from ciramrdata on reads. Writes leave rdata unchanged.
  - ack for the winner is high in the cycle following that edge.
  - Nametable latency: ack is high 3 cycles after the IDLE edge that granted the request.
- CHRWAIT:
  - chrreq held high. Counter increments each cycle.
  - chrack sampled high: chrreq=0, rdata=chrrdata on reads, go to RESP. ack follows chrack by one cycle.
  - Counter reaches TIMEOUT without chrack: chrreq=0, rdata=8'hFF on reads, err=1, go to RESP.
  - chrack arriving outside CHRWAIT is ignored.
- RESP:
  - The winner's ack is high for exactly this one cycle; all other ack bits are 0. Return to IDLE.
  - Requesters clear req at the edge on which they see ack. A request re-sampled in the following IDLE cycle is therefore a new access.
- Back-to-back: a new grant is possible on the first IDLE edge after RESP, so the minimum request spacing is 4 cycles for CIRAM.
- err and errclr:
  - errclr clears err.
  - errclr coinciding with a timeout: set wins.
- Write data: rdata is never driven by writes.

Test Plan:
- mirror=1; port 0 reads $2400, CIRAM[11'h400]=8'h5A -> ciramaddr=11'h400; ack=3'b001 exactly 3 cycles after grant; rdata=8'h5A.
- mirror=0; port 2 writes 8'h33 to $2C10 -> ciramaddr=11'h410, ciramwr=1 for one cycle; ack=3'b100; rdata unchanged.
- Ports 0, 1, 2 raise req in the same cycle, all nametable reads -> acks in order 001, 010, 100; each spaced 4 cycles; no overlap.
- Port 1 reads $1FF8; memory model acks after 5 cycles with 8'hC3 -> chrreq high 5 cycles; ack=3'b010 one cycle after chrack; rdata=8'hC3.
- TIMEOUT=4; CHR read never acked -> chrreq drops after 4 cycles; ack pulses; rdata=8'hFF; err=1; errclr pulse -> err=0.
- Reset asserted during CHRWAIT -> chrreq and busy go to 0 asynchronously; no ack; a late chrack is ignored; the next req is served normally.
